// File: rtl/matrix_mem_ctrl.sv
// Matrix operand/result memory: masked synchronous writes, registered reads,
// hardware clear sweep after reset or on request, and a rejected-access error pulse.
module matrix_mem_ctrl #(
    parameter int DATA_W = 256,
    parameter int ELEM_W = 16,
    parameter int DEPTH  = 8,
    localparam int NELEM = DATA_W / ELEM_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     addr,
    input  logic              wr_en,
    input  logic [NELEM-1:0]  wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clear,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    // Request/response contract: rd_en/wr_en are sampled on every rising edge with
    // no ready handshake. An accepted read yields rd_valid for exactly one cycle on
    // the following edge with rd_data updated; a rejected request (busy or address
    // out of range) yields a single err pulse instead and changes nothing.

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t        state, state_next;
    logic [AW-1:0] cnt, cnt_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic addr_ok;
    logic idle;
    logic rd_ok;
    logic wr_ok;
    logic req_bad;

    assign addr_ok = ({1'b0, addr} < DEPTH_L);
    assign idle    = (state == IDLE);
    assign rd_ok   = rd_en && idle && addr_ok;
    assign wr_ok   = wr_en && idle && addr_ok;
    assign req_bad = (rd_en || wr_en) && !(idle && addr_ok);
    assign busy    = (state == CLEAR);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                // clear requests during a sweep are ignored, never restart it
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Storage has no reset; the sweep that follows reset zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NELEM; k++) begin
                if (wr_mask[k]) begin
                    mem[addr][k*ELEM_W +: ELEM_W] <= wr_data[k*ELEM_W +: ELEM_W];
                end
            end
        end
    end

    // Nonblocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            err      <= req_bad;
            if (rd_ok) begin
                rd_data <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Bench for matrix_mem_ctrl: an 8-entry and a 6-entry instance share stimulus and are
// compared every cycle against an array-based model of the memory and its clear sweep.
module tb_matrix_mem_ctrl;

    localparam int DW = 256;
    localparam int EW = 16;
    localparam int NE = DW / EW;

    localparam logic [DW-1:0] PAT = 256'h0123_4567_89AB_CDEF_1122_3344_5566_7788_99AA_BBCC_DDEE_FF00_0F1E_2D3C_4B5A_6978;

    logic          clk;
    logic          reset;
    logic [2:0]    addr;
    logic          wr_en;
    logic [NE-1:0] wr_mask;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic          clear;

    logic [DW-1:0] rd_data8, rd_data6;
    logic          rd_valid8, rd_valid6, busy8, busy6, err8, err6;

    logic [DW-1:0] rd_data_o  [2];
    logic          rd_valid_o [2];
    logic          busy_o     [2];
    logic          err_o      [2];

    assign rd_data_o[0]  = rd_data8;
    assign rd_data_o[1]  = rd_data6;
    assign rd_valid_o[0] = rd_valid8;
    assign rd_valid_o[1] = rd_valid6;
    assign busy_o[0]     = busy8;
    assign busy_o[1]     = busy6;
    assign err_o[0]      = err8;
    assign err_o[1]      = err6;

    matrix_mem_ctrl #(.DATA_W(DW), .ELEM_W(EW), .DEPTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_mask(wr_mask),
        .wr_data(wr_data), .rd_en(rd_en), .clear(clear), .rd_data(rd_data8),
        .rd_valid(rd_valid8), .busy(busy8), .err(err8)
    );

    matrix_mem_ctrl #(.DATA_W(DW), .ELEM_W(EW), .DEPTH(6)) u_dut6 (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_mask(wr_mask),
        .wr_data(wr_data), .rd_en(rd_en), .clear(clear), .rd_data(rd_data6),
        .rd_valid(rd_valid6), .busy(busy6), .err(err6)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: memory contents and cycles of sweep remaining per instance
    int            dep [2] = '{8, 6};
    logic [DW-1:0] mm [2][8];
    int            busy_left [2];
    logic [DW-1:0] exp_rd [2];
    logic          exp_v [2];
    logic          exp_err [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    // driver: apply one cycle of inputs, advance the model over the edge, settle
    task automatic drive(input int rd, input int wr, input int a,
                         input logic [NE-1:0] m, input logic [DW-1:0] d, input int clr);
        logic ok, bz;
        rd_en   = (rd != 0);
        wr_en   = (wr != 0);
        addr    = 3'(a);
        wr_mask = m;
        wr_data = d;
        clear   = (clr != 0);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            ok = (a < dep[i]);
            bz = (busy_left[i] > 0);
            exp_err[i] = (rd != 0 || wr != 0) && (bz || !ok);
            exp_v[i]   = (rd != 0) && !bz && ok;
            if (exp_v[i]) exp_rd[i] = mm[i][a];
            if (wr != 0 && !bz && ok) begin
                for (int k = 0; k < NE; k++)
                    if (m[k]) mm[i][a][k*EW +: EW] = d[k*EW +: EW];
            end
            if (bz) begin
                mm[i][dep[i] - busy_left[i]] = '0;
                busy_left[i]--;
            end else if (clr != 0) begin
                busy_left[i] = dep[i];
            end
        end
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        clear = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            busy_left[i] = dep[i];
            exp_rd[i]    = '0;
            exp_v[i]     = 1'b0;
            exp_err[i]   = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({rd_valid_o[i], err_o[i], busy_o[i]} !== 3'b001 || rd_data_o[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d valid/err/busy=%b%b%b rd_data=%h, need 001 and zero",
                         i, rd_valid_o[i], err_o[i], busy_o[i], rd_data_o[i]);
            end
        end
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        apply_reset(2);
        cyc = 0;
        while (busy_o[0] === 1'b1 && cyc < 20) begin
            drive(0, 0, 0, '0, '0, 0);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({rd_valid_o[i], err_o[i], busy_o[i]} !== {exp_v[i], exp_err[i], busy_left[i] > 0}) begin
                    n_fail++;
                    $display("FAIL init_sweep dut%0d valid/err/busy=%b%b%b, need %b%b%b", i,
                             rd_valid_o[i], err_o[i], busy_o[i], exp_v[i], exp_err[i], busy_left[i] > 0);
                end
            end
        end
        n_checks++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL init_busy_len got %0d cycles, need 8", cyc);
        end
        for (int a = 0; a < 8; a++) begin
            drive(1, 0, a, '0, '0, 0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({rd_valid_o[i], err_o[i], busy_o[i]} !== {exp_v[i], exp_err[i], busy_left[i] > 0}
                    || rd_data_o[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL read_zero dut%0d addr %0d valid/err/busy=%b%b%b data=%h, need %b%b%b %h",
                             i, a, rd_valid_o[i], err_o[i], busy_o[i], rd_data_o[i],
                             exp_v[i], exp_err[i], busy_left[i] > 0, exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        drive(0, 1, 3, 16'hFFFF, PAT, 0);
        drive(1, 0, 3, '0, '0, 0);
        n_checks++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== PAT) begin
            n_fail++;
            $display("FAIL write_read valid=%b data=%h, need 1 %h", rd_valid_o[0], rd_data_o[0], PAT);
        end
        drive(0, 1, 3, 16'h0001, {DW{1'b1}}, 0);
        drive(1, 0, 3, '0, '0, 0);
        n_checks++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== {PAT[DW-1:EW], 16'hFFFF}) begin
            n_fail++;
            $display("FAIL mask_elem0 valid=%b data=%h, need 1 %h", rd_valid_o[0], rd_data_o[0],
                     {PAT[DW-1:EW], 16'hFFFF});
        end
        drive(0, 1, 3, 16'h0000, '0, 0);
        drive(1, 0, 3, '0, '0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rd_valid_o[i] !== exp_v[i] || rd_data_o[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL mask_zero dut%0d valid=%b data=%h, need %b %h", i,
                         rd_valid_o[i], rd_data_o[i], exp_v[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_rbw();
        drive(1, 1, 5, 16'hFFFF, {32{8'hA5}}, 0);
        n_checks++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== '0) begin
            n_fail++;
            $display("FAIL rbw_old valid=%b data=%h, need 1 and zero", rd_valid_o[0], rd_data_o[0]);
        end
        drive(1, 0, 5, '0, '0, 0);
        n_checks++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== {32{8'hA5}}) begin
            n_fail++;
            $display("FAIL rbw_new valid=%b data=%h, need 1 a5..a5", rd_valid_o[0], rd_data_o[0]);
        end
    endtask

    task automatic test_errors();
        int t_rd  [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
        int t_wr  [9] = '{0, 1, 1, 0, 0, 0, 0, 0, 1};
        int t_a   [9] = '{7, 6, 7, 0, 6, 0, 0, 0, 2};
        int t_clr [9] = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
        int cyc;
        for (int s = 0; s < 9; s++) begin
            drive(t_rd[s], t_wr[s], t_a[s], 16'hFFFF, rand_data(), t_clr[s]);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({rd_valid_o[i], err_o[i], busy_o[i]} !== {exp_v[i], exp_err[i], busy_left[i] > 0}
                    || rd_data_o[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL err_step%0d dut%0d valid/err/busy=%b%b%b data=%h, need %b%b%b %h",
                             s, i, rd_valid_o[i], err_o[i], busy_o[i], rd_data_o[i],
                             exp_v[i], exp_err[i], busy_left[i] > 0, exp_rd[i]);
                end
            end
        end
        cyc = 0;
        while ((busy_left[0] > 0 || busy_left[1] > 0) && cyc < 20) begin
            drive(0, 0, 0, '0, '0, 0);
            cyc++;
        end
        n_checks++;
        if (busy_o[0] !== 1'b0 || busy_o[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sweep_end busy=%b%b, need 00", busy_o[0], busy_o[1]);
        end
    endtask

    task automatic test_clear();
        int cyc;
        for (int a = 0; a < 8; a++) begin
            drive(0, 1, a, NE'($urandom_range(1, 65535)), rand_data(), 0);
        end
        drive(0, 1, 2, 16'hFFFF, rand_data(), 1);
        cyc = 0;
        while (busy_o[0] === 1'b1 && cyc < 20) begin
            drive((cyc == 0) ? 1 : 0, 0, 0, '0, '0, (cyc == 3) ? 1 : 0);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({rd_valid_o[i], err_o[i], busy_o[i]} !== {exp_v[i], exp_err[i], busy_left[i] > 0}) begin
                    n_fail++;
                    $display("FAIL clear_sweep dut%0d valid/err/busy=%b%b%b, need %b%b%b", i,
                             rd_valid_o[i], err_o[i], busy_o[i], exp_v[i], exp_err[i], busy_left[i] > 0);
                end
            end
        end
        n_checks++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL clear_busy_len got %0d cycles, need 8", cyc);
        end
        for (int a = 0; a < 8; a++) begin
            drive(1, 0, a, '0, '0, 0);
            n_checks++;
            if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== '0) begin
                n_fail++;
                $display("FAIL clear_zero addr %0d valid=%b data=%h, need 1 and zero", a,
                         rd_valid_o[0], rd_data_o[0]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        drive(0, 1, 1, 16'hFFFF, rand_data(), 0);
        drive(0, 0, 0, '0, '0, 1);
        repeat (3) drive(0, 0, 0, '0, '0, 0);
        apply_reset(2);
        cyc = 0;
        while (busy_o[0] === 1'b1 && cyc < 20) begin
            drive(0, 0, 0, '0, '0, 0);
            cyc++;
        end
        n_checks++;
        if (cyc != 8) begin
            n_fail++;
            $display("FAIL midreset_busy_len got %0d cycles, need 8", cyc);
        end
        drive(1, 0, 1, '0, '0, 0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rd_valid_o[i] !== 1'b1 || rd_data_o[i] !== '0) begin
                n_fail++;
                $display("FAIL midreset_zero dut%0d valid=%b data=%h, need 1 and zero", i,
                         rd_valid_o[i], rd_data_o[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 8; a++) drive(0, 1, a, 16'hFFFF, rand_data(), 0);
        for (int a = 0; a < 8; a++) begin
            drive(1, 0, a, '0, '0, 0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({rd_valid_o[i], err_o[i]} !== {exp_v[i], exp_err[i]} || rd_data_o[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL b2b dut%0d addr %0d valid/err=%b%b data=%h, need %b%b %h", i, a,
                             rd_valid_o[i], err_o[i], rd_data_o[i], exp_v[i], exp_err[i], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  NE'($urandom_range(0, 65535)), rand_data(), ($urandom_range(0, 40) == 0) ? 1 : 0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if ({rd_valid_o[i], err_o[i], busy_o[i]} !== {exp_v[i], exp_err[i], busy_left[i] > 0}
                    || rd_data_o[i] !== exp_rd[i]) begin
                    n_fail++;
                    $display("FAIL random cyc %0d dut%0d valid/err/busy=%b%b%b data=%h, need %b%b%b %h",
                             n, i, rd_valid_o[i], err_o[i], busy_o[i], rd_data_o[i],
                             exp_v[i], exp_err[i], busy_left[i] > 0, exp_rd[i]);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        clear   = 1'b0;
        addr    = '0;
        wr_mask = '0;
        wr_data = '0;
        #2;
        test_reset();
        test_write_read();
        test_rbw();
        test_errors();
        test_clear();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_mem_ctrl.md
Name: matrix_mem_ctrl

Overview:
- Parametrised matrix memory used by the execution engine as operand/result storage.
- Stores DEPTH entries of DATA_W bits; each entry is a row-major matrix of NELEM = DATA_W/ELEM_W elements.
- Adds over the previous generation: fully synchronous access, per-element write mask, 1-cycle registered read with valid flag, hardware clear sweep with busy flag, and out-of-range/illegal-access error pulse.

Parameters:
DATA_W, 256, entry width in bits (one 4x4 matrix of 16-bit elements); must be a multiple of ELEM_W
ELEM_W, 16, element width in bits; granularity of wr_mask
DEPTH, 8, number of entries; need not be a power of 2
AW, $clog2(DEPTH) (min 1), address width (localparam, derived)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
addr  input  AW  entry address for the current read or write
wr_en  input  1  write request, sampled on clk rising edge
wr_mask  input  DATA_W/ELEM_W  bit k=1 writes element k (bits k*ELEM_W +: ELEM_W)
wr_data  input  DATA_W  write data
rd_en  input  1  read request, sampled on clk rising edge
clear  input  1  request to zero all entries
rd_data  output  DATA_W  registered read data
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle
busy  output  1  clear sweep in progress; requests are not accepted
err  output  1  one-cycle pulse: rejected request

Behaviour:
- Reset values while reset is high: rd_data=0, rd_valid=0, err=0, busy=1, sweep counter=0, FSM=CLEAR. Array contents are not touched asynchronously.
- FSM has two states, IDLE and CLEAR.
  - CLEAR: each cycle, writes entry[cnt]=0 and increments cnt. After writing entry DEPTH-1, goes to IDLE on that edge.
  - A sweep therefore takes exactly DEPTH cycles; busy=1 throughout and drops the cycle after the last entry is zeroed.
  - IDLE: clear=1 at an edge -> CLEAR with cnt=0; busy=1 from the next cycle.
- After reset deasserts, a full sweep runs automatically, so the memory reads as all-zero once busy falls.
- Reset asserted mid-sweep restarts the sweep at entry 0.
- clear=1 while already in CLEAR is ignored, with no restart and no err.
- Write (IDLE, wr_en=1, addr<DEPTH): each element k with wr_mask[k]=1 takes wr_data; masked-off elements keep their value. wr_mask=0 is a legal no-op.
- Read (IDLE, rd_en=1, addr<DEPTH): rd_data=entry[addr] and rd_valid=1 at the following edge, i.e. 1-cycle latency.
  - rd_data holds its last value when no read completes.
  - rd_valid is high only for the cycle after an accepted read.
- Simultaneous rd_en and wr_en to the same addr: read-before-write. rd_data returns the old contents and the write takes effect.
- A request in the same cycle as clear (from IDLE) is performed normally; the sweep then zeroes it.
- Rejected requests pulse err=1 for one cycle, leave memory and rd_data unchanged, and do not raise rd_valid:
  - rd_en or wr_en with addr>=DEPTH;
  - rd_en or wr_en while busy=1.
- err with both rd_en and wr_en illegal in one cycle is a single one-cycle pulse.
- Back-to-back reads on consecutive cycles give consecutive rd_valid pulses, with full throughput of one access per cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Reset for 2 cycles, release -> busy=1 for exactly 8 cycles then 0. Then read addr 0..7 -> rd_data=0 with rd_valid each cycle after request.
- Write addr 3 with wr_data=256'h0123...CDEF (all elements distinct), wr_mask=16'hFFFF, then read addr 3 -> next-cycle rd_data equals that value and rd_valid=1.
- Write addr 3 with wr_data all-ones and wr_mask=16'h0001, then read -> element 0 = 16'hFFFF, elements 1..15 unchanged.
- Same cycle rd_en=wr_en=1 at addr 5: old value 0, new 256'hA5..A5. Expect rd_data=0, then a second read returns 256'hA5..A5.
- With DEPTH=6, access addr 7 -> err pulse, rd_valid=0, memory unchanged. Assert rd_en while busy=1 -> err pulse and no rd_valid.
- Fill all entries, pulse clear -> busy 8 cycles, all reads return 0. Assert reset at sweep cycle 4 -> sweep restarts and busy lasts 8 cycles after release.
